i_decode_hz: RTL

Parametrised successor ID stage for the MIPS pipeline. It contains the opcode decoder, the general-purpose register file with write-through bypass, the immediate extender, and the ID/EX pipeline register. New relative to the first-generation decode stage:
- load-use hazard detection with stall request
- bubble insertion on flush
- downstream hold
- synchronous reset
- parametrised data width, register count and PC width
- selectable immediate-extension mode

---
 rtl/mips_pkg.sv | 52 +++++
 rtl/gp_regfile.sv | 44 ++++
 rtl/i_decode_hz.sv | 100 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS decode stage: opcodes, control-field
// layout, the bubble constant and the opcode-to-control decoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;
  localparam int EX_REGDST   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUSRC   = 0;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = CTRL_NOP;
    case (op)
      OP_RTYPE:         c = {2'b10, 3'b000, 4'b1100};
      OP_LW:            c = {2'b11, 3'b010, 4'b0001};
      OP_SW:            c = {2'b00, 3'b001, 4'b0001};
      OP_BEQ:           c = {2'b00, 3'b100, 4'b0010};
      OP_ANDI, OP_ORI:  c = {2'b10, 3'b000, 4'b0111};
      default:          c = CTRL_NOP;
    endcase
    return c;
  endfunction

  function automatic logic is_logic_imm(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/gp_regfile.sv
// General-purpose register file: two combinational read ports, one write
// port, write-through bypass, synchronous clear. Register 0 is hardwired 0.
// Ports: i_clk, i_rst (sync, active-high), i_raddr1/2 -> o_rdata1/2,
//        i_we/i_waddr/i_wdata write port.
module gp_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [AW-1:0]     i_raddr1,
  input  logic [AW-1:0]     i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata
);

  logic [DATA_W-1:0] r_mem [NREGS];
  logic              w_wr_en;

  assign w_wr_en = i_we && (i_waddr != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NREGS; k++) r_mem[k] <= '0;
    end else if (w_wr_en) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // A write landing this edge is visible to a same-cycle read.
  always_comb begin
    o_rdata1 = r_mem[i_raddr1];
    o_rdata2 = r_mem[i_raddr2];
    if (w_wr_en && (i_waddr == i_raddr1)) o_rdata1 = i_wdata;
    if (w_wr_en && (i_waddr == i_raddr2)) o_rdata2 = i_wdata;
    if (i_raddr1 == '0) o_rdata1 = '0;
    if (i_raddr2 == '0) o_rdata2 = '0;
  end

endmodule

// File: rtl/i_decode_hz.sv
// MIPS ID stage with load-use hazard detection, flush bubbles, downstream
// hold and an ID/EX pipeline register.
// Inputs : clk, rst (sync, active-high), ifid_instr, ifid_npc, flush, hold,
//          wb_regwrite/wb_writereg/wb_writedata (write-back port).
// Outputs: stall_o (combinational); registered wb, m, ex, npc, rdata1,
//          rdata2, imm, rs_o, rt_o, rd_o.
module i_decode_hz
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NREGS      = 32,
  parameter int PC_W       = 32,
  parameter bit LOGIC_ZEXT = 1'b0,
  localparam int REG_AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ifid_instr,
  input  logic [PC_W-1:0]   ifid_npc,
  input  logic              flush,
  input  logic              hold,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_writereg,
  input  logic [DATA_W-1:0] wb_writedata,
  output logic              stall_o,
  output logic [WB_W-1:0]   wb,
  output logic [M_W-1:0]    m,
  output logic [EX_W-1:0]   ex,
  output logic [PC_W-1:0]   npc,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] imm,
  output logic [REG_AW-1:0] rs_o,
  output logic [REG_AW-1:0] rt_o,
  output logic [REG_AW-1:0] rd_o
);

  logic [5:0]        w_op;
  logic [REG_AW-1:0] w_rs, w_rt, w_rd;
  ctrl_t             w_ctrl;
  logic [DATA_W-1:0] w_rdata1, w_rdata2, w_imm;
  logic              w_load_use;

  assign w_op   = ifid_instr[31:26];
  assign w_rs   = ifid_instr[21 +: REG_AW];
  assign w_rt   = ifid_instr[16 +: REG_AW];
  assign w_rd   = ifid_instr[11 +: REG_AW];
  assign w_ctrl = decode_ctrl(w_op);

  gp_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_raddr1 (w_rs),
    .i_raddr2 (w_rt),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2),
    .i_we     (wb_regwrite),
    .i_waddr  (wb_writereg),
    .i_wdata  (wb_writedata)
  );

  always_comb begin
    w_imm = DATA_W'($signed(ifid_instr[15:0]));
    if (LOGIC_ZEXT && is_logic_imm(w_op)) w_imm = DATA_W'(ifid_instr[15:0]);
  end

  // Both source fields are compared regardless of opcode (conservative).
  assign w_load_use = m[M_MEMREAD] && (rt_o != '0) &&
                      ((rt_o == w_rs) || (rt_o == w_rt));

  // A flush kills the dependent instruction, so no stall is needed then.
  assign stall_o = hold || (w_load_use && !flush);

  // flush beats hold; data fields load on bubbles and are don't-care there.
  always_ff @(posedge clk) begin
    if (rst) begin
      {wb, m, ex} <= CTRL_NOP;
      npc    <= '0;
      rdata1 <= '0;
      rdata2 <= '0;
      imm    <= '0;
      rs_o   <= '0;
      rt_o   <= '0;
      rd_o   <= '0;
    end else if (flush || !hold) begin
      {wb, m, ex} <= (flush || w_load_use) ? CTRL_NOP : w_ctrl;
      npc    <= ifid_npc;
      rdata1 <= w_rdata1;
      rdata2 <= w_rdata2;
      imm    <= w_imm;
      rs_o   <= w_rs;
      rt_o   <= w_rt;
      rd_o   <= w_rd;
    end
  end

endmodule
